// File: rtl/vga_fb_pkg.sv
// Shared types and default geometry for the 160x120x6b frame-buffer scheduler.
package vga_fb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 6;
  localparam int FB_DEPTH  = 19200;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  typedef enum logic [1:0] {
    DISP,
    HOST,
    FILL
  } owner_e;

endpackage

// File: rtl/vga_fb_fill.sv
// Clear engine: walks 0..DEPTH-1 one write per granted slot with a latched colour,
// then pulses done for one clock.
module vga_fb_fill
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int DEPTH  = FB_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] color_in,
  input  logic              step,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] color,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    addr_d  = addr_q;
    color_d = color_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          addr_d  = '0;
          color_d = color_in;
        end
      end
      CLEAR: begin
        if (step) begin
          if (addr_q == LAST_ADDR) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == CLEAR);
  assign addr  = addr_q;
  assign color = color_q;
  assign done  = done_q;

endmodule

// File: rtl/vga_fb_sched.sv
// Slot scheduler for the single-port frame-buffer RAM: display fetch, host port, clear engine.
// Optional host readback path is enabled by defining VGA_FB_READBACK_EN.
module vga_fb_sched
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int DEPTH  = FB_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              pix_ce,
  input  logic              disp_active,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rgb,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              err_oob,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic              ph_q, ph_d;
  logic              disp_fetch_q, disp_fetch_d;
  logic [DATA_W-1:0] disp_rgb_q, disp_rgb_d;
  logic              err_oob_q, err_oob_d;

  owner_e            owner;
  logic              host_oob, host_is_wr, host_xfer;
  logic              fill_busy, fill_step;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_color;

`ifdef VGA_FB_READBACK_EN
  assign host_is_wr = host_we;
`else
  logic unused_host_we;
  assign unused_host_we = host_we;
  assign host_is_wr     = 1'b1;
`endif

  always_comb begin
    ph_d   = ~ph_q;
    pix_ce = ~ph_q;

    // Active display slots always win; idle display slots fall through to host/fill.
    if (!ph_q && disp_active) owner = DISP;
    else if (fill_busy)       owner = FILL;
    else                      owner = HOST;

    host_oob   = (host_addr >= DEPTH_A);
    host_ready = (owner == HOST) && host_valid;
    host_xfer  = host_ready;
    fill_step  = (owner == FILL);

    ram_addr  = host_addr;
    ram_wdata = host_wdata;
    ram_we    = host_xfer && host_is_wr && !host_oob;
    unique case (owner)
      DISP: begin
        ram_addr  = disp_addr;
        ram_wdata = '0;
        ram_we    = 1'b0;
      end
      FILL: begin
        ram_addr  = fill_addr;
        ram_wdata = fill_color;
        ram_we    = 1'b1;
      end
      default: ;
    endcase

    // Flag remembers whether the ph=0 slot fetched; data lands at the end of ph=1.
    disp_fetch_d = ph_q ? disp_fetch_q : disp_active;
    disp_rgb_d   = disp_rgb_q;
    if (ph_q) disp_rgb_d = disp_fetch_q ? ram_rdata : '0;

    err_oob_d = err_oob_q | (host_xfer & host_oob);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q         <= 1'b0;
      disp_fetch_q <= 1'b0;
      disp_rgb_q   <= '0;
      err_oob_q    <= 1'b0;
    end else begin
      ph_q         <= ph_d;
      disp_fetch_q <= disp_fetch_d;
      disp_rgb_q   <= disp_rgb_d;
      err_oob_q    <= err_oob_d;
    end
  end

  assign disp_rgb = disp_rgb_q;
  assign err_oob  = err_oob_q;

`ifdef VGA_FB_READBACK_EN
  logic              rd_pend_q, rd_pend_d;
  logic              rd_oob_q, rd_oob_d;
  logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
  logic [DATA_W-1:0] rd_data;

  // The RAM answers one clock after the accept, so the valid cycle passes the
  // RAM data straight through and the hold register keeps it afterwards.
  always_comb begin
    rd_pend_d   = host_xfer && !host_we;
    rd_oob_d    = host_oob;
    rd_data     = rd_oob_q ? '0 : ram_rdata;
    rd_hold_d   = rd_pend_q ? rd_data : rd_hold_q;
    host_rvalid = rd_pend_q;
    host_rdata  = rd_pend_q ? rd_data : rd_hold_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q <= 1'b0;
      rd_oob_q  <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_oob_q  <= rd_oob_d;
      rd_hold_q <= rd_hold_d;
    end
  end
`else
  assign host_rvalid = 1'b0;
  assign host_rdata  = '0;
`endif

  vga_fb_fill #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fill (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clr_start),
    .color_in(clr_color),
    .step    (fill_step),
    .busy    (fill_busy),
    .addr    (fill_addr),
    .color   (fill_color),
    .done    (clr_done)
  );

  assign clr_busy = fill_busy;

endmodule

// File: tb/tb_vga_fb_sched.sv
// Self-checking bench for vga_fb_sched with a behavioural registered RAM and a
// queue scoreboard for display fetches and host readback.
module tb_vga_fb_sched;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 19200;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pix_ce;
  logic              disp_active;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rgb;
  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              clr_start;
  logic [DATA_W-1:0] clr_color;
  logic              clr_busy;
  logic              clr_done;
  logic              err_oob;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem     [0:32767];
  logic [DATA_W-1:0] ref_mem [0:32767];
  logic [DATA_W-1:0] exp_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_ph;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  vga_fb_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .disp_active(disp_active),
    .disp_addr  (disp_addr),
    .disp_rgb   (disp_rgb),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .err_oob    (err_oob),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  task automatic tick();
    @(negedge clk);
    exp_ph = ~exp_ph;
  endtask

  task automatic idle_inputs();
    disp_active = 1'b0; disp_addr = '0;
    host_valid  = 1'b0; host_we = 1'b1; host_addr = '0; host_wdata = '0;
    clr_start   = 1'b0; clr_color = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    exp_ph  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({disp_rgb, host_rvalid, host_rdata, clr_busy, clr_done, err_oob} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got rgb=%0h rv=%0b rd=%0h busy=%0b done=%0b oob=%0b expected all 0",
               disp_rgb, host_rvalid, host_rdata, clr_busy, clr_done, err_oob);
    end
    n_checks++;
    if (pix_ce !== 1'b1 || ram_we !== 1'b0 || host_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_comb: got pix_ce=%0b ram_we=%0b ready=%0b expected 1/0/0", pix_ce, ram_we, host_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_ph  = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      disp_active = 1'b1; disp_addr = '0;
      #1;
      n_checks++;
      if (pix_ce !== ~exp_ph || ram_we !== 1'b0 || disp_rgb !== '0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got pix_ce=%0b ram_we=%0b rgb=%0h expected %0b/0/0",
                 i, pix_ce, ram_we, disp_rgb, ~exp_ph);
      end
    end
  endtask

  task automatic test_display();
    int idx = 0;
    logic [DATA_W-1:0] last = '0;
    logic have_last = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 26; cyc++) begin
      tick();
      if (!exp_ph) begin
        disp_active = (idx < 10);
        disp_addr   = (idx < 10) ? ADDR_W'(idx) : '0;
      end
      #1;
      if (!exp_ph) begin
        if (exp_q.size() > 0) begin
          last = exp_q.pop_front(); have_last = 1'b1;
          n_checks++;
          if (disp_rgb !== last) begin
            n_fail++;
            $display("FAIL disp_fetch: got %0h expected %0h", disp_rgb, last);
          end
        end
        if (disp_active) begin
          n_checks++;
          if (ram_addr !== disp_addr || ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL disp_slot_addr: got addr=%0d we=%0b expected %0d/0", ram_addr, ram_we, disp_addr);
          end
          exp_q.push_back(ref_mem[disp_addr]);
          idx++;
        end else begin
          exp_q.push_back('0);
        end
      end else if (have_last) begin
        n_checks++;
        if (disp_rgb !== last) begin
          n_fail++;
          $display("FAIL disp_hold: got %0h expected %0h", disp_rgb, last);
        end
      end
    end
  endtask

  task automatic test_host_with_display();
    logic wrote = 1'b0;
    int   n_we = 0;
    exp_q.delete();
    disp_active = 1'b1; disp_addr = ADDR_W'(100);
    host_we = 1'b1; host_addr = ADDR_W'(100); host_wdata = 6'h2A;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      host_valid = !wrote;
      #1;
      if (ram_we) n_we++;
      if (!exp_ph) begin
        if (exp_q.size() > 0) begin
          logic [DATA_W-1:0] e = exp_q.pop_front();
          n_checks++;
          if (disp_rgb !== e) begin
            n_fail++;
            $display("FAIL hd_disp_fetch: got %0h expected %0h", disp_rgb, e);
          end
        end
        n_checks++;
        if (host_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== ADDR_W'(100)) begin
          n_fail++;
          $display("FAIL hd_disp_slot: got ready=%0b we=%0b addr=%0d expected 0/0/100", host_ready, ram_we, ram_addr);
        end
        exp_q.push_back(ref_mem[100]);
      end else begin
        n_checks++;
        if (host_ready !== !wrote) begin
          n_fail++;
          $display("FAIL hd_ready_ph1: got %0b expected %0b", host_ready, !wrote);
        end
        if (!wrote) begin
          n_checks++;
          if (ram_we !== 1'b1 || ram_addr !== ADDR_W'(100) || ram_wdata !== 6'h2A) begin
            n_fail++;
            $display("FAIL hd_write: got we=%0b addr=%0d data=%0h expected 1/100/2a", ram_we, ram_addr, ram_wdata);
          end
          wrote = 1'b1;
          ref_mem[100] = 6'h2A;
        end
      end
    end
    n_checks++;
    if (n_we != 1) begin
      n_fail++;
      $display("FAIL hd_write_count: got %0d expected 1", n_we);
    end
    host_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    disp_active = 1'b0; host_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      host_valid = 1'b1; host_addr = ADDR_W'(200 + i); host_wdata = DATA_W'(6'h30 + i);
      #1;
      n_checks++;
      if (host_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== host_addr || ram_wdata !== host_wdata) begin
        n_fail++;
        $display("FAIL b2b_accept%0d: got ready=%0b we=%0b addr=%0d data=%0h expected 1/1/%0d/%0h",
                 i, host_ready, ram_we, ram_addr, ram_wdata, host_addr, host_wdata);
      end
      ref_mem[200 + i] = DATA_W'(6'h30 + i);
    end
    tick(); host_valid = 1'b0;
    tick(); #1;
    n_checks++;
    if (disp_rgb !== '0) begin
      n_fail++;
      $display("FAIL b2b_blank_rgb: got %0h expected 0", disp_rgb);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[200 + i] !== ref_mem[200 + i]) begin
        n_fail++;
        $display("FAIL b2b_ram%0d: got %0h expected %0h", i, mem[200 + i], ref_mem[200 + i]);
      end
    end
  endtask

  task automatic test_oob();
    disp_active = 1'b0;
    tick();
    host_valid = 1'b1; host_we = 1'b1; host_addr = ADDR_W'(DEPTH); host_wdata = 6'h03;
    #1;
    n_checks++;
    if (err_oob !== 1'b0 || host_ready !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL oob_accept: got oob=%0b ready=%0b we=%0b expected 0/1/0", err_oob, host_ready, ram_we);
    end
    tick(); host_valid = 1'b0; #1;
    n_checks++;
    if (err_oob !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_set: got %0b expected 1", err_oob);
    end
    tick(); host_valid = 1'b1; host_addr = ADDR_W'(210); host_wdata = 6'h01;
    ref_mem[210] = 6'h01;
    tick(); host_valid = 1'b0;
    repeat (4) tick();
    #1;
    n_checks++;
    if (err_oob !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_sticky: got %0b expected 1", err_oob);
    end
  endtask

  task automatic test_readback();
    exp_q.delete();
`ifdef VGA_FB_READBACK_EN
    tick();
    disp_active = 1'b0; host_valid = 1'b1; host_we = 1'b0; host_addr = ADDR_W'(100);
    #1;
    n_checks++;
    if (host_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ADDR_W'(100)) begin
      n_fail++;
      $display("FAIL rb_accept: got ready=%0b we=%0b addr=%0d expected 1/0/100", host_ready, ram_we, ram_addr);
    end
    exp_q.push_back(ref_mem[100]);
    tick(); host_valid = 1'b0; host_we = 1'b1; #1;
    n_checks++;
    if (host_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rb_rvalid: got %0b expected 1", host_rvalid);
    end else begin
      logic [DATA_W-1:0] e = exp_q.pop_front();
      n_checks++;
      if (host_rdata !== e) begin
        n_fail++;
        $display("FAIL rb_rdata: got %0h expected %0h", host_rdata, e);
      end
    end
    tick(); #1;
    n_checks++;
    if (host_rvalid !== 1'b0 || host_rdata !== 6'h2A) begin
      n_fail++;
      $display("FAIL rb_hold: got rv=%0b rd=%0h expected 0/2a", host_rvalid, host_rdata);
    end
`else
    tick();
    disp_active = 1'b0; host_valid = 1'b1; host_we = 1'b0; host_addr = ADDR_W'(220); host_wdata = 6'h11;
    #1;
    n_checks++;
    if (host_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== ADDR_W'(220)) begin
      n_fail++;
      $display("FAIL norb_write: got ready=%0b we=%0b addr=%0d expected 1/1/220", host_ready, ram_we, ram_addr);
    end
    ref_mem[220] = 6'h11;
    tick(); host_valid = 1'b0; host_we = 1'b1; #1;
    n_checks++;
    if (host_rvalid !== 1'b0 || host_rdata !== '0) begin
      n_fail++;
      $display("FAIL norb_tied: got rv=%0b rd=%0h expected 0/0", host_rvalid, host_rdata);
    end
`endif
  endtask

  task automatic test_clear();
    int   busy_cnt = 0, done_cnt = 0, bad_ready = 0, bad_disp = 0, bad_fill = 0, bad_done = 0, bad_mem = 0;
    logic prev_busy;
    tick();
    if (!exp_ph) tick();
    // Start in a ph=1 cycle together with a host transfer (OOB so RAM is untouched).
    clr_start = 1'b1; clr_color = 6'h15; disp_active = 1'b1; disp_addr = '0;
    host_valid = 1'b1; host_we = 1'b1; host_addr = ADDR_W'(20000); host_wdata = 6'h3F;
    #1;
    n_checks++;
    if (host_ready !== 1'b1 || clr_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_start_xfer: got ready=%0b busy=%0b expected 1/0", host_ready, clr_busy);
    end
    prev_busy = clr_busy;
    for (int cyc = 0; cyc < 2 * DEPTH + 10; cyc++) begin
      tick();
      clr_start = 1'b0;
      disp_addr = ADDR_W'(cyc % DEPTH);
      #1;
      if (clr_busy) begin
        busy_cnt++;
        if (host_ready) bad_ready++;
        if (exp_ph && !(ram_we && ram_wdata == 6'h15)) bad_fill++;
      end
      if (!exp_ph && (ram_we || ram_addr != disp_addr)) bad_disp++;
      if (clr_done) begin
        done_cnt++;
        if (!(prev_busy && !clr_busy)) bad_done++;
      end
      prev_busy = clr_busy;
    end
    host_valid = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a] !== 6'h15) bad_mem++;
      ref_mem[a] = 6'h15;
    end
    n_checks++;
    if (busy_cnt != 2 * DEPTH) begin
      n_fail++; $display("FAIL clr_busy_len: got %0d expected %0d", busy_cnt, 2 * DEPTH);
    end
    n_checks++;
    if (done_cnt != 1 || bad_done != 0) begin
      n_fail++; $display("FAIL clr_done_pulse: got count=%0d misplaced=%0d expected 1/0", done_cnt, bad_done);
    end
    n_checks++;
    if (bad_ready != 0 || bad_fill != 0) begin
      n_fail++; $display("FAIL clr_host_slots: got ready_hi=%0d bad_fill=%0d expected 0/0", bad_ready, bad_fill);
    end
    n_checks++;
    if (bad_disp != 0) begin
      n_fail++; $display("FAIL clr_disp_slots: got %0d disturbed slots expected 0", bad_disp);
    end
    n_checks++;
    if (bad_mem != 0) begin
      n_fail++; $display("FAIL clr_contents: got %0d wrong locations expected 0", bad_mem);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic found = 1'b0;
    int   done_seen = 0;
    tick();
    if (!exp_ph) tick();
    clr_start = 1'b1; clr_color = 6'h0A; disp_active = 1'b1; disp_addr = '0;
    for (int cyc = 0; cyc < 2000 && !found; cyc++) begin
      tick(); clr_start = 1'b0; #1;
      if (ram_we && ram_addr == ADDR_W'(500)) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL mid_reach500: got timeout expected write to 500");
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort: got busy=%0b done=%0b expected 0/0", clr_busy, clr_done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1; exp_ph = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick(); #1;
      if (clr_done) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || clr_busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_done: got done=%0d busy=%0b expected 0/0", done_seen, clr_busy);
    end
    tick();
    clr_start = 1'b1; clr_color = 6'h2B;
    found = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      tick(); clr_start = 1'b0; #1;
      if (ram_we) begin
        found = 1'b1;
        n_checks++;
        if (ram_addr !== '0 || ram_wdata !== 6'h2B) begin
          n_fail++; $display("FAIL mid_restart: got addr=%0d data=%0h expected 0/2b", ram_addr, ram_wdata);
        end
      end
    end
    n_checks++;
    if (!found || clr_busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_restart_seen: got found=%0b busy=%0b expected 1/1", found, clr_busy);
    end
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) begin
      mem[a]     = DATA_W'(a);
      ref_mem[a] = DATA_W'(a);
    end
    exp_ph = 1'b0;
    test_reset();
    test_idle();
    test_display();
    test_host_with_display();
    test_back_to_back();
    test_oob();
    test_readback();
    test_clear();
    test_reset_mid_clear();
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
